// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: Avalon-MM slave that queues ROM-write commands from software
// and replays them as timed write strobes on the NES PRG/CHR ROM write ports,
// holding the NES core in reset for the whole load session.
//
// Ports
//   CLK, RESET                   clock, asynchronous active-low reset
//   AVL_ADDR/CS/READ/WRITE       Avalon-MM register access (0 CTRL, 1 CMD, 2 STAT, 3 CSUM)
//   AVL_WRITEDATA                write data
//   AVL_READDATA                 registered read data, valid the cycle after the read
//   AVL_WAITREQ                  combinational stall while a CMD write hits a full FIFO
//   ROM_ADDR, ROM_DATA           ROM write address/data, held between writes
//   PRG_ROM_WRITE, CHR_ROM_WRITE ROM write strobes
//   NES_HOLD                     holds NES CPU/PPU in reset while high
//
// Optional feature: define ROM_LOAD_CHECKSUM_EN to add the CSUM register
// (16-bit wrapping sum of committed data bytes); otherwise CSUM reads 0.
module rom_load_ctrl #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned WR_CYCLES  = 2,
    parameter int unsigned HOLD_TAIL  = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  AVL_ADDR,
    input  logic        AVL_CS,
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA,
    output logic        AVL_WAITREQ,
    output logic [15:0] ROM_ADDR,
    output logic [7:0]  ROM_DATA,
    output logic        PRG_ROM_WRITE,
    output logic        CHR_ROM_WRITE,
    output logic        NES_HOLD
);

    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned WCW = 4;
    localparam int unsigned TCW = 8;

    typedef struct packed {
        logic        tgt;
        logic [7:0]  data;
        logic [15:0] addr;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_TAIL} state_e;

    state_e          state_q, state_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    logic            fin_q, fin_d;
    logic            prg_q, prg_d, chr_q, chr_d, hold_q, hold_d;
    logic            start_c, commit_c, tail_done_c;

    cmd_t            mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [15:0]     rom_addr_q;
    logic [7:0]      rom_data_q;
    logic            tgt_q;
    logic            err_q, done_q;
    logic [15:0]     commits_q;
    logic [31:0]     rdata_q;
    logic [31:0]     csum_rd_c;

    // Bus decode
    logic wr_c, rd_c, ctrl_wr_c, cmd_wr_c, stat_wr_c;
    logic in_sess_c, empty_c, full_c, pop_c, push_c;
    logic unused_c;

    assign wr_c      = AVL_CS & AVL_WRITE;
    assign rd_c      = AVL_CS & AVL_READ;
    assign ctrl_wr_c = wr_c && (AVL_ADDR == 2'd0);
    assign cmd_wr_c  = wr_c && (AVL_ADDR == 2'd1);
    assign stat_wr_c = wr_c && (AVL_ADDR == 2'd2);
    assign unused_c  = ^AVL_WRITEDATA[30:24];

    assign in_sess_c = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign empty_c   = (cnt_q == '0);
    assign full_c    = (cnt_q == CW'(FIFO_DEPTH));
    assign pop_c     = (state_q == S_LOAD) && !empty_c;
    // A pop in the same cycle frees the slot, so a full FIFO does not stall then.
    assign push_c    = cmd_wr_c && in_sess_c && (!full_c || pop_c);
    assign AVL_WAITREQ = cmd_wr_c && in_sess_c && full_c && !pop_c;

    // FSM next state and registered strobe/hold outputs
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        fin_d       = fin_q;
        start_c     = 1'b0;
        commit_c    = 1'b0;
        tail_done_c = 1'b0;
        if (ctrl_wr_c && AVL_WRITEDATA[1] && in_sess_c) fin_d = 1'b1;
        unique case (state_q)
            S_IDLE: if (ctrl_wr_c && AVL_WRITEDATA[0]) begin
                state_d = S_LOAD;
                start_c = 1'b1;
                fin_d   = AVL_WRITEDATA[1];
            end
            S_LOAD: if (!empty_c) begin
                state_d = S_WRITE;
                wcnt_d  = '0;
            end else if (fin_q) begin
                state_d = S_TAIL;
                tcnt_d  = '0;
                fin_d   = 1'b0;
            end
            // Strobe trails the WRITE state by one cycle: the first WRITE cycle is
            // address setup, and the last strobe cycle overlaps the next LOAD.
            S_WRITE: if (wcnt_q == WCW'(WR_CYCLES - 1)) begin
                state_d  = S_LOAD;
                commit_c = 1'b1;
            end else begin
                wcnt_d = wcnt_q + WCW'(1);
            end
            S_TAIL: if (tcnt_q == TCW'(HOLD_TAIL)) begin
                state_d     = S_IDLE;
                tail_done_c = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TCW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        prg_d  = (state_q == S_WRITE) &&  tgt_q;
        chr_d  = (state_q == S_WRITE) && !tgt_q;
        hold_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            fin_q   <= 1'b0;
            prg_q   <= 1'b0;
            chr_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            fin_q   <= fin_d;
            prg_q   <= prg_d;
            chr_q   <= chr_d;
            hold_q  <= hold_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge CLK) begin
        if (push_c) mem_q[wr_ptr_q] <= cmd_t'({AVL_WRITEDATA[31], AVL_WRITEDATA[23:0]});
    end

    // FIFO pointers/count, ROM latch, flags, counters, read data
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            tgt_q      <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            commits_q  <= '0;
            rdata_q    <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                rom_addr_q <= mem_q[rd_ptr_q].addr;
                rom_data_q <= mem_q[rd_ptr_q].data;
                tgt_q      <= mem_q[rd_ptr_q].tgt;
            end
            if (push_c && !pop_c)      cnt_q <= cnt_q + CW'(1);
            else if (pop_c && !push_c) cnt_q <= cnt_q - CW'(1);
            if (stat_wr_c)                       err_q <= 1'b0;
            else if (cmd_wr_c && !in_sess_c)     err_q <= 1'b1;
            if (stat_wr_c)        done_q <= 1'b0;
            else if (tail_done_c) done_q <= 1'b1;
            if (start_c)       commits_q <= '0;
            else if (commit_c) commits_q <= commits_q + 16'd1;
            if (rd_c) begin
                unique case (AVL_ADDR)
                    2'd0:    rdata_q <= {16'b0, 8'(cnt_q), 4'b0, err_q, done_q,
                                         (state_q != S_IDLE), full_c};
                    2'd2:    rdata_q <= {16'b0, commits_q};
                    2'd3:    rdata_q <= csum_rd_c;
                    default: rdata_q <= '0;
                endcase
            end
        end
    end

`ifdef ROM_LOAD_CHECKSUM_EN
    logic [15:0] sum_q;

    // Wrapping sum of data bytes, accumulated as each write commits
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)        sum_q <= '0;
        else if (start_c)  sum_q <= '0;
        else if (commit_c) sum_q <= sum_q + 16'(rom_data_q);
    end
    assign csum_rd_c = {16'b0, sum_q};
`else
    assign csum_rd_c = '0;
`endif

    assign AVL_READDATA  = rdata_q;
    assign ROM_ADDR      = rom_addr_q;
    assign ROM_DATA      = rom_data_q;
    assign PRG_ROM_WRITE = prg_q;
    assign CHR_ROM_WRITE = chr_q;
    assign NES_HOLD      = hold_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl; ROM strobes and register reads are
// checked against queued expectations.
module tb_rom_load_ctrl;

    localparam int unsigned WRC = 2;
    localparam logic [31:0] START  = 32'h1;
    localparam logic [31:0] FINISH = 32'h2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  AVL_ADDR = '0;
    logic        AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
    logic [31:0] AVL_WRITEDATA = '0;
    logic [31:0] AVL_READDATA;
    logic        AVL_WAITREQ;
    logic [15:0] ROM_ADDR;
    logic [7:0]  ROM_DATA;
    logic        PRG_ROM_WRITE, CHR_ROM_WRITE, NES_HOLD;

    rom_load_ctrl #(.FIFO_DEPTH(16), .WR_CYCLES(WRC), .HOLD_TAIL(8)) dut (
        .CLK(CLK), .RESET(RESET), .AVL_ADDR(AVL_ADDR), .AVL_CS(AVL_CS),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .AVL_WAITREQ(AVL_WAITREQ),
        .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .PRG_ROM_WRITE(PRG_ROM_WRITE),
        .CHR_ROM_WRITE(CHR_ROM_WRITE), .NES_HOLD(NES_HOLD)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0, n_err = 0;
    int cyc = 0, fall_cyc = 0, idle_cyc = 0;
    bit gap_en = 1'b0;
    logic [24:0] rom_q[$];
    logic [31:0] rd_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] rom_exp(input logic [31:0] cmd);
        return {cmd[31], cmd[15:0], cmd[23:16]};
    endfunction

    function automatic logic [63:0] outs();
        return 64'({AVL_READDATA, AVL_WAITREQ, ROM_ADDR, ROM_DATA,
                    PRG_ROM_WRITE, CHR_ROM_WRITE, NES_HOLD});
    endfunction

    // ROM-side monitor: pops an expected command on every strobe rise
    logic        prev_s = 1'b0;
    logic [23:0] prev_ad = '0, rise_ad = '0;
    int          width = 0, gap = 0;
    bit          seen_fall = 1'b0;
    always @(negedge CLK) begin
        logic s;
        logic [24:0] e;
        s = PRG_ROM_WRITE | CHR_ROM_WRITE;
        if (!gap_en) seen_fall = 1'b0;
        if (s && !prev_s) begin
            check("strobe_excl", 64'(PRG_ROM_WRITE & CHR_ROM_WRITE), 64'd0);
            check("strobe_expected", 64'(rom_q.size() != 0), 64'd1);
            if (rom_q.size() != 0) begin
                e = rom_q.pop_front();
                check("rom_cmd", 64'({PRG_ROM_WRITE, ROM_ADDR, ROM_DATA}), 64'(e));
            end
            check("addr_setup", 64'(prev_ad), 64'({ROM_ADDR, ROM_DATA}));
            if (gap_en && seen_fall) check("strobe_gap", 64'(gap), 64'd1);
            rise_ad = {ROM_ADDR, ROM_DATA};
            width = 1;
        end else if (s) begin
            width++;
        end else if (prev_s) begin
            if (RESET) begin
                check("strobe_width", 64'(width), 64'(WRC));
                check("addr_hold", 64'(prev_ad), 64'(rise_ad));
            end
            fall_cyc = cyc;
            seen_fall = 1'b1;
            gap = 1;
        end else begin
            gap++;
        end
        prev_s  = s;
        prev_ad = {ROM_ADDR, ROM_DATA};
    end

    task automatic avl_write(input logic [1:0] a, input logic [31:0] d, output bit stalled);
        bit w, ok;
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
        AVL_ADDR = a; AVL_WRITEDATA = d;
        stalled = 1'b0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #4 w = AVL_WAITREQ;
            @(posedge CLK);
            if (!w) begin ok = 1'b1; break; end
            stalled = 1'b1;
            @(negedge CLK);
        end
        if (!ok) check("write_timeout", 64'd0, 64'd1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bit st;
        avl_write(a, d, st);
    endtask

    task automatic avl_idle();
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_READ = 1'b0;
    endtask

    task automatic avl_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = a;
        rd_q.push_back(exp);
        @(posedge CLK);
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        e = rd_q.pop_front();
        check(tag, 64'(AVL_READDATA), 64'(e));
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        avl_idle();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (!NES_HOLD && !PRG_ROM_WRITE && !CHR_ROM_WRITE) begin
                ok = 1'b1;
                idle_cyc = cyc;
                break;
            end
        end
        check({tag, "_idle"}, 64'(ok), 64'd1);
        check({tag, "_drained"}, 64'(rom_q.size()), 64'd0);
    endtask

    task automatic cmd(input logic [31:0] c);
        rom_q.push_back(rom_exp(c));
        wr(2'd1, c);
    endtask

    initial begin
        bit st, seen;
        int first_stall;
        logic [31:0] c;

        // Reset
        #2 RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_outs", outs(), 64'd0);
        RESET = 1'b1;
        avl_read(2'd0, 32'h0, "reset_ctrl");

        // Single PRG write, then the hold tail
        wr(2'd0, START);
        cmd(32'h8012_1234);
        wr(2'd0, FINISH);
        wait_idle("single");
        check("hold_tail", 64'(idle_cyc - fall_cyc), 64'd9);
        avl_read(2'd0, 32'h4, "single_ctrl_done");
        avl_read(2'd2, 32'h1, "single_stat");
`ifdef ROM_LOAD_CHECKSUM_EN
        avl_read(2'd3, 32'h12, "single_csum");
`else
        avl_read(2'd3, 32'h0, "single_csum");
`endif

        // CMD write in IDLE is dropped and flags ERR
        wr(2'd1, 32'h80AA_5555);
        avl_idle();
        repeat (6) @(negedge CLK);
        avl_read(2'd0, 32'hC, "idle_cmd_err");
        wr(2'd2, 32'h0);
        avl_read(2'd0, 32'h0, "stat_clear");

        // Five back-to-back pushes: the fifth coincides with a pop at cnt = 3
        wr(2'd0, START);
        cmd(32'h8001_0010);
        cmd(32'h0002_0011);
        cmd(32'h8003_0012);
        cmd(32'h0004_0013);
        cmd(32'h8005_0014);
        avl_read(2'd0, 32'h0000_0302, "push_pop_cnt3");
        wr(2'd0, FINISH);
        wait_idle("cnt3");
        avl_read(2'd2, 32'h5, "cnt3_stat");

        // Checksum of 0xFF + 0x02
        wr(2'd0, START);
        cmd(32'h00FF_0100);
        cmd(32'h8002_0101);
        wr(2'd0, FINISH);
        wait_idle("csum");
`ifdef ROM_LOAD_CHECKSUM_EN
        avl_read(2'd3, 32'h0101, "csum_value");
`else
        avl_read(2'd3, 32'h0, "csum_value");
`endif

        // Burst: pops every WRC+1 cycles while pushes arrive every cycle, so
        // occupancy reaches 16 after push 24 and push 25 is the first to stall.
        gap_en = 1'b1;
        wr(2'd0, START);
        first_stall = -1;
        for (int k = 0; k < 25; k++) begin
            c = {k[0], 7'b0, 8'(k * 7 + 1), 16'(32'h2000 + k)};
            rom_q.push_back(rom_exp(c));
            avl_write(2'd1, c, st);
            if (st && first_stall < 0) first_stall = k + 1;
        end
        check("first_waitreq", 64'(first_stall), 64'd25);
        wr(2'd0, FINISH);
        wait_idle("burst");
        gap_en = 1'b0;
        avl_read(2'd2, 32'd25, "burst_stat");

        // Reset while the PRG strobe is high
        wr(2'd0, START);
        cmd(32'h8033_4321);
        avl_idle();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (PRG_ROM_WRITE) begin seen = 1'b1; break; end
        end
        check("midwrite_strobe_seen", 64'(seen), 64'd1);
        #2 RESET = 1'b0;
        #1 check("midwrite_reset_outs", outs(), 64'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        avl_read(2'd0, 32'h0, "post_reset_ctrl");
        avl_read(2'd2, 32'h0, "post_reset_stat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
